cplx_accumulator: RTL and testbench

CPLX_ACCUMULATOR -- requirements
Module: cplx_accumulator

---
 rtl/cplx_accumulator.sv | 149 ++++++++++++++
 tb/tb_cplx_accumulator.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/cplx_accumulator.sv
// Complex frame accumulator: sums LEN signed samples per frame, then scales, saturates and holds the result.
// Optional rounding before the output shift is enabled by defining CPLX_ACC_ROUND_EN.
module cplx_accumulator #(
  parameter int IN_W  = 10,
  parameter int OUT_W = 8,
  parameter int ACC_W = 16,
  parameter int LEN   = 8,
  parameter int SHIFT = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    sub,
  input  logic signed [IN_W-1:0]  in_re,
  input  logic signed [IN_W-1:0]  in_im,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_re,
  output logic signed [OUT_W-1:0] out_im,
  output logic                    sat
);

  localparam int CNT_W = $clog2(LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

  // Saturation bounds expressed in the ACC_W+1-bit scaling domain.
  localparam logic signed [ACC_W:0] SAT_MAX =
    {{(ACC_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN =
    {{(ACC_W + 2 - OUT_W){1'b1}}, {(OUT_W - 1){1'b0}}};

`ifdef CPLX_ACC_ROUND_EN
  localparam int unsigned RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [ACC_W:0] RND =
    (SHIFT > 0) ? ((ACC_W + 1)'(1) << RND_POS) : '0;
`endif

  typedef enum logic {
    ACC,
    HOLD
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]         cnt;
  logic signed [ACC_W-1:0]  acc_re, acc_im;
  logic signed [ACC_W-1:0]  x_re, x_im;
  logic signed [ACC_W-1:0]  base_re, base_im;
  logic signed [ACC_W-1:0]  acc_re_nxt, acc_im_nxt;
  logic [OUT_W:0]           sc_re, sc_im;
  logic                     accept;
  logic                     last;

  // Returns {clamped, value}: widen by one bit so rounding cannot overflow, then shift and clamp.
  function automatic logic [OUT_W:0] scale_sat(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W:0] ext;
    logic signed [ACC_W:0] sh;
    ext = {a[ACC_W-1], a};
`ifdef CPLX_ACC_ROUND_EN
    ext = ext + RND;
`endif
    sh = ext >>> SHIFT;
    if (sh > SAT_MAX) begin
      return {1'b1, SAT_MAX[OUT_W-1:0]};
    end else if (sh < SAT_MIN) begin
      return {1'b1, SAT_MIN[OUT_W-1:0]};
    end else begin
      return {1'b0, sh[OUT_W-1:0]};
    end
  endfunction

  assign accept = in_ready && in_valid && !clr;
  assign last   = (cnt == CNT_LAST);

  always_comb begin
    x_re       = {{(ACC_W - IN_W){in_re[IN_W-1]}}, in_re};
    x_im       = {{(ACC_W - IN_W){in_im[IN_W-1]}}, in_im};
    // The first sample of a frame starts from zero rather than the stale sum.
    base_re    = (cnt == '0) ? '0 : acc_re;
    base_im    = (cnt == '0) ? '0 : acc_im;
    acc_re_nxt = sub ? (base_re - x_re) : (base_re + x_re);
    acc_im_nxt = sub ? (base_im - x_im) : (base_im + x_im);
    sc_re      = scale_sat(acc_re_nxt);
    sc_im      = scale_sat(acc_im_nxt);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ACC;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (clr) begin
      state_nxt = ACC;
    end else begin
      case (state)
        ACC:     if (accept && last) state_nxt = HOLD;
        HOLD:    if (out_ready) state_nxt = ACC;
        default: state_nxt = ACC;
      endcase
    end
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ACC:     in_ready  = 1'b1;
      HOLD:    out_valid = 1'b1;
      default: in_ready  = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      acc_re <= '0;
      acc_im <= '0;
      out_re <= '0;
      out_im <= '0;
      sat    <= 1'b0;
    end else if (clr) begin
      cnt    <= '0;
      acc_re <= '0;
      acc_im <= '0;
      out_re <= '0;
      out_im <= '0;
      sat    <= 1'b0;
    end else if (accept) begin
      acc_re <= acc_re_nxt;
      acc_im <= acc_im_nxt;
      if (last) begin
        cnt    <= '0;
        out_re <= sc_re[OUT_W-1:0];
        out_im <= sc_im[OUT_W-1:0];
        sat    <= sc_re[OUT_W] | sc_im[OUT_W];
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_cplx_accumulator.sv
// Directed bench for cplx_accumulator (IN_W=10, OUT_W=8, ACC_W=16, LEN=4, SHIFT=1).
module tb_cplx_accumulator;

  logic              clk;
  logic              rst;
  logic              clr;
  logic              in_valid;
  logic              in_ready;
  logic              sub;
  logic signed [9:0] in_re;
  logic signed [9:0] in_im;
  logic              out_valid;
  logic              out_ready;
  logic signed [7:0] out_re;
  logic signed [7:0] out_im;
  logic              sat;

  int n_cmp;
  int n_err;

  cplx_accumulator #(
    .IN_W (10),
    .OUT_W(8),
    .ACC_W(16),
    .LEN  (4),
    .SHIFT(1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .sub      (sub),
    .in_re    (in_re),
    .in_im    (in_im),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_re   (out_re),
    .out_im   (out_im),
    .sat      (sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
    sub      = 1'b0;
    in_re    = '0;
    in_im    = '0;
  endtask

  task automatic push(input int re, input int im, input bit sb);
    in_valid = 1'b1;
    in_re    = 10'(re);
    in_im    = 10'(im);
    sub      = sb;
    @(negedge clk);
  endtask

  // Four samples, then check latency: no result before the 4th edge, result right after it.
  task automatic frame(input string tag, input int re[4], input int im[4], input bit sb[4]);
    for (int i = 0; i < 4; i++) begin
      push(re[i], im[i], sb[i]);
      if (i == 2) check({tag, ".early_valid"}, out_valid, 0);
    end
    idle();
    check({tag, ".out_valid"}, out_valid, 1);
    check({tag, ".in_ready"}, in_ready, 0);
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst       = 1'b0;
    clr       = 1'b0;
    out_ready = 1'b0;
    idle();

    #12;
    check("rst.out_valid", out_valid, 0);
    check("rst.in_ready", in_ready, 1);
    check("rst.out_re", out_re, 0);
    check("rst.out_im", out_im, 0);
    check("rst.sat", sat, 0);
    @(negedge clk);
    rst = 1'b1;

    // Plain sum: re 100 >> 1 = 50, im -20 >> 1 = -10
    frame("sum", '{10, 20, 30, 40}, '{-5, -5, -5, -5}, '{0, 0, 0, 0});
    check("sum.out_re", out_re, 50);
    check("sum.out_im", out_im, -10);
    check("sum.sat", sat, 0);
    release_result();
    check("sum.rel_valid", out_valid, 0);
    check("sum.rel_ready", in_ready, 1);

    // Subtract from zero: re -400 >> 1 = -200 clamps to -128
    frame("neg", '{100, 100, 100, 100}, '{0, 0, 0, 0}, '{1, 1, 1, 1});
    check("neg.out_re", out_re, -128);
    check("neg.out_im", out_im, 0);
    check("neg.sat", sat, 1);

    // Backpressure: held result stays put and inputs are ignored
    for (int i = 0; i < 5; i++) begin
      in_valid  = 1'b1;
      in_re     = 10'sd7;
      in_im     = 10'sd7;
      out_ready = 1'b0;
      @(negedge clk);
      check("hold.out_valid", out_valid, 1);
      check("hold.in_ready", in_ready, 0);
      check("hold.out_re", out_re, -128);
      check("hold.out_im", out_im, 0);
      check("hold.sat", sat, 1);
    end
    idle();
    release_result();
    check("hold.rel_ready", in_ready, 1);
    check("hold.rel_valid", out_valid, 0);

    // Abort a partial frame with clr (in_valid also high on that edge)
    push(50, 0, 0);
    push(50, 0, 0);
    clr = 1'b1;
    push(50, 0, 0);
    clr = 1'b0;
    idle();
    check("clr.in_ready", in_ready, 1);
    check("clr.out_valid", out_valid, 0);
    frame("clr", '{1, 1, 1, 1}, '{0, 0, 0, 0}, '{0, 0, 0, 0});
    check("clr.out_re", out_re, 2);
    check("clr.out_im", out_im, 0);
    check("clr.sat", sat, 0);

    // clr while holding a result discards it
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clrhold.out_valid", out_valid, 0);
    check("clrhold.in_ready", in_ready, 1);

    // Mixed add/subtract with both components clamping: re 800 -> 400 -> 127, im -400 -> -200 -> -128
    frame("pos", '{200, 200, 200, 200}, '{-100, -100, -100, -100}, '{0, 0, 0, 0});
    check("pos.out_re", out_re, 127);
    check("pos.out_im", out_im, -128);
    check("pos.sat", sat, 1);
    release_result();
    // re 10-20+30-5 = 15, im 0-4+0+0 = -4
    frame("mix", '{10, 20, 30, 5}, '{0, 4, 0, 0}, '{0, 1, 0, 1});
`ifdef CPLX_ACC_ROUND_EN
    check("mix.out_re", out_re, 8);
`else
    check("mix.out_re", out_re, 7);
`endif
    check("mix.out_im", out_im, -2);
    check("mix.sat", sat, 0);

    // Asynchronous reset while holding a result
    #2 rst = 1'b0;
    #1;
    check("arst.out_valid", out_valid, 0);
    check("arst.in_ready", in_ready, 1);
    check("arst.out_re", out_re, 0);
    check("arst.out_im", out_im, 0);
    check("arst.sat", sat, 0);
    @(negedge clk);
    rst = 1'b1;

    // Asynchronous reset mid-frame loses the partial sum
    push(50, 50, 0);
    push(50, 50, 0);
    idle();
    #2 rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Rounding vs truncation: re 3, im -3
    frame("rnd", '{1, 1, 1, 0}, '{-1, -1, -1, 0}, '{0, 0, 0, 0});
`ifdef CPLX_ACC_ROUND_EN
    check("rnd.out_re", out_re, 2);
    check("rnd.out_im", out_im, -1);
`else
    check("rnd.out_re", out_re, 1);
    check("rnd.out_im", out_im, -2);
`endif
    check("rnd.sat", sat, 0);
    release_result();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
